// File: rtl/urp_pcie_pkg.sv
// Shared types and constants for the URP PCIe memory-write TLP path.
// Holds the MWr format/type codes, the framer state encoding and the 4-DW header layout.
package urp_pcie_pkg;

    localparam logic [2:0] FMT_MWR32 = 3'b010;
    localparam logic [2:0] FMT_MWR64 = 3'b011;
    localparam logic [4:0] TYPE_MWR  = 5'b00000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_HDR2    = 3'd3,
        ST_HDR3    = 3'd4,
        ST_PAYLOAD = 3'd5
    } state_t;

    typedef struct packed {
        logic [31:0] dw0;
        logic [31:0] dw1;
        logic [31:0] dw2;
        logic [31:0] dw3;
    } mwr_hdr_t;

endpackage

// File: rtl/urp_pcie_mwr_hdr_gen.sv
// Combinational MWr header builder: DW0..DW3 from a DW-aligned address, length and tag.
// A 3DW header leaves dw3 at zero; the framer never presents it in that case.
module urp_pcie_mwr_hdr_gen
    import urp_pcie_pkg::*;
#(
    parameter logic [15:0] REQ_ID = 16'h0100
) (
    input  logic [61:0] i_addr_dw,
    input  logic [9:0]  i_len,
    input  logic [7:0]  i_tag,
    output mwr_hdr_t    o_hdr
);

    logic       w_is64;
    logic [3:0] w_last_be;

    always_comb begin
        w_is64    = |i_addr_dw[61:30];
        w_last_be = (i_len == 10'd1) ? 4'h0 : 4'hF;

        o_hdr.dw0 = {(w_is64 ? FMT_MWR64 : FMT_MWR32), TYPE_MWR, 14'b0, i_len};
        o_hdr.dw1 = {REQ_ID, i_tag, w_last_be, 4'hF};
        if (w_is64) begin
            o_hdr.dw2 = i_addr_dw[61:30];
            o_hdr.dw3 = {i_addr_dw[29:0], 2'b00};
        end else begin
            o_hdr.dw2 = {i_addr_dw[29:0], 2'b00};
            o_hdr.dw3 = '0;
        end
    end

endmodule

// File: rtl/urp_pcie_mwr_tlp_framer.sv
// MWr TLP framer: accepts one (addr, len) request, emits a 3DW/4DW header and then
// streams len payload DWs straight from a first-word-fall-through FIFO.
module urp_pcie_mwr_tlp_framer
    import urp_pcie_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter logic [15:0] REQ_ID     = 16'h0100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [9:0]            req_len_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  fifo_rden_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_sop_o,
    output logic                  tx_eop_o,
    output logic                  busy_o
);

    state_t      r_state;
    logic [7:0]  r_tag;
    logic [7:0]  r_cur_tag;
    logic [10:0] r_cnt;
    logic [61:0] r_addr_dw;
    logic [9:0]  r_len;

    mwr_hdr_t    w_hdr;
    logic        w_is64;
    logic        w_tx_valid;
    logic        w_pop;
    logic        w_unused_addr_lo;

    // Byte-offset bits carry no information for a DW-aligned write.
    assign w_unused_addr_lo = &{1'b0, req_addr_i[1:0]};

    urp_pcie_mwr_hdr_gen #(
        .REQ_ID (REQ_ID)
    ) u_hdr_gen (
        .i_addr_dw (r_addr_dw),
        .i_len     (r_len),
        .i_tag     (r_cur_tag),
        .o_hdr     (w_hdr)
    );

    assign w_is64 = |r_addr_dw[61:30];

    always_comb begin
        w_tx_valid = 1'b0;
        tx_data_o  = '0;
        tx_sop_o   = 1'b0;
        tx_eop_o   = 1'b0;
        case (r_state)
            ST_HDR0: begin
                w_tx_valid = 1'b1;
                tx_data_o  = w_hdr.dw0;
                tx_sop_o   = 1'b1;
            end
            ST_HDR1: begin
                w_tx_valid = 1'b1;
                tx_data_o  = w_hdr.dw1;
            end
            ST_HDR2: begin
                w_tx_valid = 1'b1;
                tx_data_o  = w_hdr.dw2;
            end
            ST_HDR3: begin
                w_tx_valid = 1'b1;
                tx_data_o  = w_hdr.dw3;
            end
            ST_PAYLOAD: begin
                w_tx_valid = ~fifo_empty_i;
                tx_data_o  = fifo_rdata_i;
                tx_eop_o   = (r_cnt == 11'd1) & ~fifo_empty_i;
            end
            default: ;
        endcase
        w_pop = (r_state == ST_PAYLOAD) & w_tx_valid & tx_ready_i;
    end

    assign tx_valid_o  = w_tx_valid;
    assign fifo_rden_o = w_pop;
    assign req_ready_o = rst_n & (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tag     <= '0;
            r_cur_tag <= '0;
            r_cnt     <= '0;
            r_addr_dw <= '0;
            r_len     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_addr_dw <= req_addr_i[63:2];
                        r_len     <= req_len_i;
                        r_cnt     <= (req_len_i == 10'd0) ? 11'd1024 : {1'b0, req_len_i};
                        r_cur_tag <= r_tag;
                        r_tag     <= r_tag + 8'd1;
                        r_state   <= ST_HDR0;
                    end
                end
                ST_HDR0: if (tx_ready_i) r_state <= ST_HDR1;
                ST_HDR1: if (tx_ready_i) r_state <= ST_HDR2;
                ST_HDR2: if (tx_ready_i) r_state <= w_is64 ? ST_HDR3 : ST_PAYLOAD;
                ST_HDR3: if (tx_ready_i) r_state <= ST_PAYLOAD;
                ST_PAYLOAD: begin
                    if (w_pop) begin
                        r_cnt <= r_cnt - 11'd1;
                        if (r_cnt == 11'd1) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_urp_pcie_mwr_tlp_framer.sv
// Directed bench for the MWr TLP framer: scoreboarded beats, FWFT FIFO model, ready throttling.
module tb_urp_pcie_mwr_tlp_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [63:0] req_addr_i = '0;
    logic [9:0]  req_len_i = '0;
    logic        fifo_empty_i = 1'b1;
    logic [31:0] fifo_rdata_i = 32'hDEAD_BEEF;
    logic        fifo_rden_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b1;
    logic [31:0] tx_data_o;
    logic        tx_sop_o;
    logic        tx_eop_o;
    logic        busy_o;

    always #5 clk = ~clk;

    urp_pcie_mwr_tlp_framer #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (64),
        .REQ_ID     (16'h0100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_len_i    (req_len_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_rden_o  (fifo_rden_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .tx_data_o    (tx_data_o),
        .tx_sop_o     (tx_sop_o),
        .tx_eop_o     (tx_eop_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic        hdr;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] fifo_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned pops = 0;
    int unsigned exp_seq = 1;
    int unsigned fifo_seq = 1;
    logic [7:0]  exp_tag = 8'h00;
    int unsigned rdy_mode = 0;
    logic        pop_pending = 1'b0;
    logic        stall_hdr = 1'b0;
    logic [31:0] stall_data = '0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // FIFO pop and ready throttling take effect just after the edge that performed the handshake.
    always @(posedge clk) begin
        #1;
        if (pop_pending === 1'b1) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pops++;
        end
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_rdata_i = (fifo_q.size() == 0) ? 32'hDEAD_BEEF : fifo_q[0];
        tx_ready_i   = (rdy_mode == 1) ? ~tx_ready_i : 1'b1;
    end

    always @(negedge clk) begin
        beat_t b;
        if (stall_hdr) begin
            check1("hdr_hold_valid", tx_valid_o, 1'b1);
            check32("hdr_hold_data", tx_data_o, stall_data);
        end
        stall_hdr = 1'b0;
        check1("req_ready", req_ready_o, rst_n & ~busy_o);
        if (fifo_rden_o === 1'b1) check1("pop_underflow", fifo_empty_i, 1'b0);
        if (tx_valid_o === 1'b1 && tx_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                check32("beat_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                b = exp_q.pop_front();
                check32("beat_data", tx_data_o, b.d);
                check1("beat_sop", tx_sop_o, b.sop);
                check1("beat_eop", tx_eop_o, b.eop);
                check1("beat_pop", fifo_rden_o, ~b.hdr);
            end
        end else if (fifo_rden_o === 1'b1) begin
            check1("pop_no_handshake", fifo_rden_o, 1'b0);
        end
        if (tx_valid_o === 1'b1 && tx_ready_i === 1'b0 && exp_q.size() > 0 && exp_q[0].hdr) begin
            stall_hdr  = 1'b1;
            stall_data = tx_data_o;
        end
        pop_pending = fifo_rden_o;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fill(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            fifo_q.push_back(32'hCAFE_0000 + fifo_seq);
            fifo_seq++;
        end
    endtask

    task automatic push_beat(input logic [31:0] d, input logic sop, input logic eop, input logic hdr);
        beat_t b;
        b.d = d; b.sop = sop; b.eop = eop; b.hdr = hdr;
        exp_q.push_back(b);
    endtask

    task automatic do_req(input logic [63:0] addr, input logic [9:0] len,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3, input logic is64);
        int unsigned n;
        for (int i = 0; i < 5000 && req_ready_o !== 1'b1; i++) tick();
        check1("req_ready_wait", req_ready_o, 1'b1);
        n = (len == 10'd0) ? 1024 : int'(len);
        push_beat(d0, 1'b1, 1'b0, 1'b1);
        push_beat(d1, 1'b0, 1'b0, 1'b1);
        push_beat(d2, 1'b0, 1'b0, 1'b1);
        if (is64) push_beat(d3, 1'b0, 1'b0, 1'b1);
        for (int unsigned k = 0; k < n; k++) begin
            push_beat(32'hCAFE_0000 + exp_seq, 1'b0, k == n - 1, 1'b0);
            exp_seq++;
        end
        exp_tag = exp_tag + 8'd1;
        req_addr_i  = addr;
        req_len_i   = len;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        check1("hdr0_valid_latency", tx_valid_o, 1'b1);
        check1("hdr0_sop_latency", tx_sop_o, 1'b1);
        check1("busy_after_accept", busy_o, 1'b1);
    endtask

    task automatic req_auto(input logic [63:0] addr, input logic [9:0] len);
        logic        is64;
        logic [31:0] d0, d1, d2, d3;
        is64 = (addr[63:32] != 32'h0);
        d0 = {(is64 ? 3'b011 : 3'b010), 5'b00000, 14'b0, len};
        d1 = {16'h0100, exp_tag, ((len == 10'd1) ? 4'h0 : 4'hF), 4'hF};
        d2 = is64 ? addr[63:32] : {addr[31:2], 2'b00};
        d3 = {addr[31:2], 2'b00};
        do_req(addr, len, d0, d1, d2, d3, is64);
    endtask

    task automatic wait_done(input string tag, input int unsigned budget);
        for (int unsigned i = 0; i < budget && (exp_q.size() != 0 || busy_o !== 1'b0); i++) tick();
        check32(tag, 32'(exp_q.size()), 32'd0);
        check1({tag, "_idle"}, busy_o, 1'b0);
    endtask

    initial begin
        int unsigned p0;

        rst_n = 1'b0;
        repeat (3) tick();
        check1("rst_req_ready", req_ready_o, 1'b0);
        rst_n = 1'b1;
        tick();
        check1("rst_req_ready_rel", req_ready_o, 1'b1);
        check1("rst_tx_valid", tx_valid_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        check1("rst_rden", fifo_rden_o, 1'b0);
        check32("rst_tx_data", tx_data_o, 32'h0);

        // 1: 3DW, single DW
        p0 = pops;
        fill(1);
        do_req(64'h0000_0000_1000_0040, 10'd1,
               32'h4000_0001, 32'h0100_000F, 32'h1000_0040, 32'h0, 1'b0);
        wait_done("t1_done", 200);
        check32("t1_pops", pops - p0, 32'd1);

        // 2: 4DW, ready toggling
        rdy_mode = 1;
        p0 = pops;
        fill(4);
        do_req(64'h0000_0001_0000_0080, 10'd4,
               32'h6000_0004, 32'h0100_01FF, 32'h0000_0001, 32'h0000_0080, 1'b1);
        wait_done("t2_done", 200);
        check32("t2_pops", pops - p0, 32'd4);
        rdy_mode = 0;
        tick();

        // 3: len=0 means 1024 DWs
        p0 = pops;
        fill(1024);
        req_auto(64'h0000_0000_0000_1000, 10'd0);
        wait_done("t3_done", 3000);
        check32("t3_pops", pops - p0, 32'd1024);

        // 4: FIFO runs dry mid-payload
        p0 = pops;
        fill(3);
        req_auto(64'h0000_00AB_0000_2000, 10'd8);
        for (int i = 0; i < 200 && pops - p0 < 3; i++) tick();
        check32("t4_pops_partial", pops - p0, 32'd3);
        repeat (4) tick();
        check1("t4_valid_dropped", tx_valid_o, 1'b0);
        check1("t4_no_pop_empty", fifo_rden_o, 1'b0);
        check1("t4_still_busy", busy_o, 1'b1);
        check32("t4_pops_held", pops - p0, 32'd3);
        fill(5);
        wait_done("t4_done", 200);
        check32("t4_pops", pops - p0, 32'd8);

        // 5: 257 back-to-back requests, tag wraps
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_tag = 8'h00;
        tick();
        p0 = pops;
        for (int unsigned i = 0; i < 257; i++) begin
            fill(1);
            req_auto(64'h0000_0000_0004_0000 + 64'(i * 64), 10'd1);
        end
        wait_done("t5_done", 200);
        check32("t5_pops", pops - p0, 32'd257);

        // 6: reset during payload beat 2
        p0 = pops;
        fill(2);
        req_auto(64'h0000_0000_0000_3000, 10'd4);
        for (int i = 0; i < 200 && pops - p0 < 1; i++) tick();
        check32("t6_first_pop", pops - p0, 32'd1);
        check1("t6_beat2_valid", tx_valid_o, 1'b1);
        rst_n = 1'b0;
        tick();
        check1("t6_valid_after_rst", tx_valid_o, 1'b0);
        check1("t6_rden_after_rst", fifo_rden_o, 1'b0);
        check1("t6_busy_after_rst", busy_o, 1'b0);
        rst_n = 1'b1;
        exp_q.delete();
        fifo_q.delete();
        fifo_seq = exp_seq;
        exp_tag = 8'h00;
        tick();
        check1("t6_ready_after_rst", req_ready_o, 1'b1);
        fill(1);
        req_auto(64'h0000_0000_0000_4000, 10'd1);
        wait_done("t6_done", 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
